// File: rtl/bcd_tick_counter_display.sv
// Slow-clock step detector driving a 4-digit BCD up/down counter with wrap,
// time-multiplexed onto a common-anode seven-segment display.
module bcd_tick_counter_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        inp_clk,
    input  logic        rst,
    input  logic        slow_clk,
    input  logic        run,
    input  logic        up_down,
    input  logic        clear,
    output logic [15:0] count_bcd,
    output logic        wrap,
    output logic        step,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic [15:0]            inc_val;
    logic [15:0]            dec_val;
    logic                   inc_carry;
    logic                   dec_borrow;
    logic [REF_W-1:0]       ref_cnt;
    logic [1:0]             digit_idx;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Flops reset high so a slow_clk already high at reset release is not a rising edge.
    always_ff @(posedge inp_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev   <= 1'b1;
            step   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            prev   <= sync_q[SYNC_STAGES-1];
            step   <= sync_q[SYNC_STAGES-1] & ~prev;
        end
    end

    // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
    always_comb begin
        inc_val    = count_bcd;
        dec_val    = count_bcd;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inc_carry) begin
                if (count_bcd[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (count_bcd[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge inp_clk or posedge rst) begin
        if (rst) begin
            count_bcd <= 16'h0000;
            wrap      <= 1'b0;
        end else if (clear) begin
            count_bcd <= 16'h0000;
            wrap      <= 1'b0;
        end else if (step && run) begin
            if (up_down) begin
                count_bcd <= inc_val;
                wrap      <= inc_carry;
            end else begin
                count_bcd <= dec_val;
                wrap      <= dec_borrow;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    always_ff @(posedge inp_clk or posedge rst) begin
        if (rst) begin
            ref_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            ref_cnt   <= ref_cnt + REF_W'(1);
        end
    end

    always_ff @(posedge inp_clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= seg_decode(count_bcd[{digit_idx, 2'b00} +: 4]);
        end
    end

endmodule

// File: tb/tb_bcd_tick_counter_display.sv
// Directed bench for bcd_tick_counter_display: step detection, BCD counting,
// wrap, hold, clear priority, display scan and mid-operation reset.
module tb_bcd_tick_counter_display;

    logic        inp_clk;
    logic        rst;
    logic        slow_clk;
    logic        run;
    logic        up_down;
    logic        clear;
    logic [15:0] count_bcd;
    logic        wrap;
    logic        step;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks     = 0;
    int failures   = 0;
    int step_seen  = 0;
    int wrap_seen  = 0;
    int lat;
    int s0;
    int found;

    logic [3:0] exp_an   [4];
    logic [6:0] exp_seg  [4];

    bcd_tick_counter_display #(
        .REFRESH_DIV(4),
        .SYNC_STAGES(2)
    ) dut (
        .inp_clk  (inp_clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .run      (run),
        .up_down  (up_down),
        .clear    (clear),
        .count_bcd(count_bcd),
        .wrap     (wrap),
        .step     (step),
        .seg      (seg),
        .an       (an)
    );

    initial inp_clk = 1'b0;
    always #5 inp_clk = ~inp_clk;

    always @(negedge inp_clk) begin
        if (!rst) begin
            if (step === 1'b1) step_seen = step_seen + 1;
            if (wrap === 1'b1) wrap_seen = wrap_seen + 1;
        end
    end

    task automatic tick();
        @(posedge inp_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise slow_clk and count edges (sampling edge = 1) until step is seen; 0 if never.
    task automatic do_step(output int l);
        slow_clk = 1'b1;
        l = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (step === 1'b1) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic full_step(output int l);
        do_step(l);
        tick();
        slow_clk = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        exp_an[0] = 4'b1110;  exp_seg[0] = 7'b0011001;
        exp_an[1] = 4'b1101;  exp_seg[1] = 7'b0110000;
        exp_an[2] = 4'b1011;  exp_seg[2] = 7'b0100100;
        exp_an[3] = 4'b0111;  exp_seg[3] = 7'b1111001;

        rst      = 1'b1;
        slow_clk = 1'b1;
        run      = 1'b1;
        up_down  = 1'b1;
        clear    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_an", 16'(an), 16'(4'b1110));
        chk("rst_seg", 16'(seg), 16'(7'b1000000));
        chk("rst_step", 16'(step), 16'h0);
        chk("rst_wrap", 16'(wrap), 16'h0);
        repeat (10) tick();
        chk("rst_no_step", 16'(step_seen), 16'd0);
        chk("rst_count", count_bcd, 16'h0000);

        slow_clk = 1'b0;
        repeat (3) tick();
        step_seen = 0;
        wrap_seen = 0;
        for (int n = 0; n < 12; n++) begin
            full_step(lat);
            chk("step_latency", 16'(lat), 16'd3);
        end
        chk("up12_steps", 16'(step_seen), 16'd12);
        chk("up12_count", count_bcd, 16'h0012);
        chk("up12_nowrap", 16'(wrap_seen), 16'd0);

        up_down = 1'b0;
        for (int n = 0; n < 14; n++) full_step(lat);
        chk("preload_9998", count_bcd, 16'h9998);

        up_down   = 1'b1;
        wrap_seen = 0;
        full_step(lat);
        chk("inc_9999", count_bcd, 16'h9999);
        chk("inc_9999_nowrap", 16'(wrap_seen), 16'd0);
        do_step(lat);
        tick();
        chk("wrap_up_count", count_bcd, 16'h0000);
        chk("wrap_up_pulse", 16'(wrap), 16'h1);
        tick();
        chk("wrap_up_single", 16'(wrap), 16'h0);
        slow_clk = 1'b0;
        repeat (3) tick();

        up_down = 1'b0;
        do_step(lat);
        tick();
        chk("wrap_dn_count", count_bcd, 16'h9999);
        chk("wrap_dn_pulse", 16'(wrap), 16'h1);
        tick();
        chk("wrap_dn_single", 16'(wrap), 16'h0);
        slow_clk = 1'b0;
        repeat (3) tick();

        run = 1'b0;
        s0  = step_seen;
        for (int n = 0; n < 5; n++) full_step(lat);
        chk("hold_count", count_bcd, 16'h9999);
        chk("hold_steps", 16'(step_seen - s0), 16'd5);

        run     = 1'b1;
        up_down = 1'b1;
        do_step(lat);
        chk("clr_step_present", 16'(step), 16'h1);
        clear = 1'b1;
        tick();
        chk("clr_count", count_bcd, 16'h0000);
        chk("clr_wrap", 16'(wrap), 16'h0);
        clear    = 1'b0;
        slow_clk = 1'b0;
        repeat (3) tick();
        chk("clr_count_held", count_bcd, 16'h0000);

        for (int n = 0; n < 1234; n++) full_step(lat);
        chk("ramp_1234", count_bcd, 16'h1234);

        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (an === 4'b0111) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("scan_find_msd", 16'(found), 16'd1);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (an === 4'b1110) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("scan_find_lsd", 16'(found), 16'd1);
        for (int k = 0; k < 16; k++) begin
            chk("scan_an", 16'(an), 16'(exp_an[k / 4]));
            chk("scan_seg", 16'(seg), 16'(exp_seg[k / 4]));
            tick();
        end

        slow_clk = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", count_bcd, 16'h0000);
        chk("mid_rst_an", 16'(an), 16'(4'b1110));
        chk("mid_rst_seg", 16'(seg), 16'(7'b1000000));
        chk("mid_rst_step", 16'(step), 16'h0);
        chk("mid_rst_wrap", 16'(wrap), 16'h0);
        tick();
        tick();
        rst = 1'b0;
        s0  = step_seen;
        repeat (10) tick();
        chk("mid_rst_no_step", 16'(step_seen - s0), 16'd0);
        chk("mid_rst_count_after", count_bcd, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_tick_counter_display.md
Name: bcd_tick_counter_display

Overview:
- Downstream consumer of the slow divided clock (about 3 Hz toggle output of the clock divider).
- Brings that signal into the fast board-clock domain and converts each rising edge into a one-cycle step pulse.
- Each step drives a 4-digit BCD up/down counter with wrap-around.
- The count is time-multiplexed onto a common-anode 4-digit seven-segment display.

Parameters:
- REFRESH_DIV, 50000: inp_clk cycles each digit stays lit before the scan advances. Must be ≥ 2.
- SYNC_STAGES, 2: synchroniser flops on slow_clk. Must be ≥ 2.

Ports:
- inp_clk  input  1  board clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- slow_clk  input  1  divided clock from the divider; treated as an asynchronous data input.
- run  input  1  1 = count on steps; 0 = hold.
- up_down  input  1  1 = increment; 0 = decrement.
- clear  input  1  synchronous clear of the count.
- count_bcd  output  16  four BCD digits; [3:0] is least significant.
- wrap  output  1  one-cycle pulse on a 9999→0000 or 0000→9999 transition.
- step  output  1  one-cycle pulse per detected slow_clk rising edge, regardless of run.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  output  4  active-low digit enables, one-hot-low; an[0] is the least significant digit.

Behaviour:
- Reset (async assert, released synchronously by the environment) sets:
  - synchroniser flops and the edge-history flop to 1, so a slow_clk already high at release gives no step;
  - count_bcd = 16'h0000, wrap = 0, step = 0;
  - refresh counter = 0, digit index = 0, an = 4'b1110, seg = 7'b1000000.
- Step generation:
  - step = sync_out & ~prev, registered.
  - step asserts SYNC_STAGES+1 inp_clk cycles after the first rising inp_clk edge that samples slow_clk high.
  - Falling edges are ignored. Exactly one step per slow_clk rising edge.
- Count update, evaluated every cycle in this priority:
  - clear = 1: count = 0000, wrap = 0. Same-cycle step is discarded.
  - else if step = 1 and run = 1:
    - up_down = 1: BCD increment with per-digit carry (digit 9 → 0, carry into next). 9999 → 0000 with wrap = 1.
    - up_down = 0: BCD decrement with per-digit borrow (digit 0 → 9). 0000 → 9999 with wrap = 1.
  - else hold, wrap = 0.
  - Count and wrap are registered: the new value appears the cycle after step is high.
  - count_bcd never holds a non-BCD nibble.
- Display scan:
  - Refresh counter runs 0..REFRESH_DIV-1 continuously, independent of run/clear.
  - At terminal count it returns to 0 and the digit index advances 0→1→2→3→0.
  - an and seg are registered from the digit index and the current count, so a count change shows on the lit digit within 1 cycle.
- Segment patterns {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble = 1111111 (unreachable).
- Reset mid-operation: all state returns to reset values immediately. A slow_clk edge in flight through the synchroniser is lost.
- run deasserted: steps are still reported on the step output but the count holds; the display keeps scanning.

Test Plan:
- Bench settings: REFRESH_DIV = 4, SYNC_STAGES = 2.
- Reset with slow_clk held high, release, hold 10 cycles → step never asserts; count_bcd = 0000; an = 1110; seg = 1000000.
- run = 1, up_down = 1, 12 slow_clk rising edges → exactly 12 step pulses, each 3 cycles after the sampling edge; count_bcd = 16'h0012; wrap stays 0.
- Preload count to 9998 by stepping, then 2 up steps → 9999, then 0000 with a single-cycle wrap on the second. Next, up_down = 0 and 1 step → 9999 with wrap = 1.
- run = 0, 5 steps → count unchanged, 5 step pulses seen. clear asserted in the same cycle as a step with run = 1 → count = 0000, wrap = 0.
- Count = 16'h1234, observe 16 cycles → an cycles 1110, 1101, 1011, 0111, each held 4 cycles; seg = 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
- Assert rst mid-scan, one cycle after a slow_clk rise → outputs at reset values in the same cycle; no step after release.
